lvdt_demod_phase_ctrl: RTL and testbench
========================================

LVDT_DEMOD_PHASE_CTRL -- requirements
Module: lvdt_demod_phase_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of demodulator phase channels, range 1..8.
REQ-002 Parameter PHASE_W, default 8: phase word width, range 4..16; one LSB = 360/2^PHASE_W degrees.
REQ-003 Parameter STEP_MAX, default 4: maximum phase change per channel per sync_strobe, range 1..2^(PHASE_W-1).
REQ-004 Ports: clk  in  1  sole clock; all logic on rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: address  in  4  register select; chipselect  in  1; write_n  in  1  active-low write; read_n  in  1  active-low read.
REQ-007 Ports: writedata  in  32; readdata  out  32  registered read data.
REQ-008 Ports: sync_strobe  in  1  one-clk pulse at excitation period start, synchronous to clk.
REQ-009 Ports: out_phase  out  NUM_CH*PHASE_W  active phase words, channel 0 in LSBs.
REQ-010 Ports: busy  out  1  high while a commit is pending or any channel is slewing.

Function
REQ-011 Address map: 0..NUM_CH-1 = SHADOW[n] (R/W, writedata[PHASE_W-1:0]); 8 = CTRL (W: bit0 COMMIT, bit1 IMMEDIATE; R: bit1 = IMMEDIATE mode); 9 = STATUS (R: bit0 PENDING, bits[8+n] SLEW[n]); 10+n for n<NUM_CH = ACTIVE[n] (R only); all other reads return 0, all other writes are ignored.
REQ-012 Write accepted when chipselect=1 and write_n=0; read when chipselect=1 and read_n=0; readdata updates on the next clk edge (1-cycle latency) and holds until the next read; unused upper bits read 0.
REQ-013 Global FSM states IDLE and PENDING; a CTRL write with bit0=1 moves IDLE->PENDING (PENDING->PENDING if already pending).
REQ-014 In PENDING with IMMEDIATE=0: on the next sync_strobe, TARGET[n] <= SHADOW[n] for all n simultaneously, then FSM -> IDLE.
REQ-015 In PENDING with IMMEDIATE=1: on the next clk edge, TARGET[n] and ACTIVE[n] <= SHADOW[n] for all n, SLEW[n] cleared, FSM -> IDLE; sync_strobe is not required.
REQ-016 A COMMIT write coinciding with sync_strobe does not use that strobe; transfer occurs on the following strobe.
REQ-017 A SHADOW write coinciding with a strobe transfer: TARGET takes the pre-write SHADOW value; the new value waits for the next commit.
REQ-018 Per-channel FSM states IDLE and SLEW; SLEW[n]=1 whenever ACTIVE[n] != TARGET[n].
REQ-019 On each sync_strobe with SLEW[n]=1, ACTIVE[n] moves by the shortest wrapped path: d = (TARGET-ACTIVE) mod 2^PHASE_W; if d < 2^(PHASE_W-1), ACTIVE += min(d, STEP_MAX); else ACTIVE -= min(2^PHASE_W-d, STEP_MAX); all arithmetic modulo 2^PHASE_W.
REQ-020 d exactly 2^(PHASE_W-1) slews in the negative direction.
REQ-021 A strobe that transfers a new TARGET does not also step ACTIVE; stepping starts on the next strobe.
REQ-022 A new TARGET arriving mid-slew redirects from the current ACTIVE value without a discontinuity.
REQ-023 out_phase is driven directly from the ACTIVE registers; busy = PENDING or OR of SLEW[n], combinational from registers.

Reset
REQ-024 While reset=1: SHADOW, TARGET, ACTIVE = 0, IMMEDIATE = 0, FSMs = IDLE, readdata = 0, out_phase = 0, busy = 0.
REQ-025 Reset asserted mid-slew or while pending aborts the operation immediately; no transfer occurs after release.
REQ-026 Register writes are ignored while reset=1.

Verification (NUM_CH=2, PHASE_W=8, STEP_MAX=4)
REQ-027 Write SHADOW0=10, COMMIT, then 4 strobes -> strobe1 TARGET0=10 with ACTIVE0=0; strobes 2-4 give ACTIVE0=4, 8, 10; busy falls after the final step.
REQ-028 ACTIVE0=250, SHADOW0=3, commit -> steps 254, 2, 3 (wrap through 0); ACTIVE0=0 with target 128 -> steps 252, 248 (negative on tie).
REQ-029 IMMEDIATE=1, SHADOW1=0x55, COMMIT with no strobe -> out_phase[15:8]=0x55 two clks after the write, busy never asserted past the pending cycle.
REQ-030 COMMIT write and sync_strobe in the same cycle -> TARGET unchanged on that strobe, transferred on the next; SHADOW write coinciding with the transfer -> old value transferred.
REQ-031 Reset pulse mid-slew (ACTIVE0=8 toward 40) -> out_phase=0, busy=0, STATUS=0, and no movement on subsequent strobes.
REQ-032 Read address 11 (ACTIVE1) and address 15 (unmapped) -> readdata equals ACTIVE1 one clk later, and 0 for address 15.

Source files
------------

// File: rtl/lvdt_demod_phase_ctrl.sv
// LVDT demodulator reference-phase controller: shadowed phase words committed on the
// excitation sync strobe (or immediately), then slewed along the shortest wrapped path.
module lvdt_demod_phase_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int PHASE_W  = 8,
  parameter int STEP_MAX = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic                        read_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  input  logic                        sync_strobe,
  output logic [NUM_CH*PHASE_W-1:0]   out_phase,
  output logic                        busy
);

  localparam logic [PHASE_W-1:0] HALF_C = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] STEP_C = PHASE_W'(STEP_MAX);

  typedef enum logic {G_IDLE = 1'b0, G_PENDING = 1'b1} gstate_t;

  gstate_t            gstate_r, gstate_next_s;
  logic [PHASE_W-1:0] shadow_r [NUM_CH];
  logic [PHASE_W-1:0] target_r [NUM_CH];
  logic [PHASE_W-1:0] active_r [NUM_CH];
  logic [PHASE_W-1:0] step_next_s [NUM_CH];
  logic               immediate_r;
  logic [31:0]        readdata_r;
  logic [31:0]        rdata_s;
  logic [NUM_CH-1:0]  slew_s;
  logic               wr_s, rd_s, commit_s, xfer_strobe_s, xfer_imm_s;
  logic               unused_wdata_s;

  // One slew step; a distance of exactly half a turn goes negative.
  function automatic logic [PHASE_W-1:0] slew_step(input logic [PHASE_W-1:0] act,
                                                   input logic [PHASE_W-1:0] tgt);
    logic [PHASE_W-1:0] d, back, m;
    d    = tgt - act;
    back = {PHASE_W{1'b0}} - d;
    if (d < HALF_C) begin
      m = (d < STEP_C) ? d : STEP_C;
      slew_step = act + m;
    end else begin
      m = (back < STEP_C) ? back : STEP_C;
      slew_step = act - m;
    end
  endfunction

  assign wr_s           = chipselect & ~write_n;
  assign rd_s           = chipselect & ~read_n;
  assign commit_s       = wr_s & (address == 4'd8) & writedata[0];
  assign unused_wdata_s = ^writedata[31:PHASE_W];

  // Per-channel slew status and the candidate next ACTIVE value.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      slew_s[n]      = (active_r[n] != target_r[n]);
      step_next_s[n] = slew_step(active_r[n], target_r[n]);
    end
  end

  // Commit FSM; a commit write in the same cycle as a strobe never consumes that strobe.
  always_comb begin
    gstate_next_s = gstate_r;
    xfer_strobe_s = 1'b0;
    xfer_imm_s    = 1'b0;
    case (gstate_r)
      G_IDLE: begin
        if (commit_s) gstate_next_s = G_PENDING;
        else          gstate_next_s = G_IDLE;
      end
      G_PENDING: begin
        if (commit_s) begin
          gstate_next_s = G_PENDING;
        end else if (immediate_r) begin
          xfer_imm_s    = 1'b1;
          gstate_next_s = G_IDLE;
        end else if (sync_strobe) begin
          xfer_strobe_s = 1'b1;
          gstate_next_s = G_IDLE;
        end else begin
          gstate_next_s = G_PENDING;
        end
      end
      default: gstate_next_s = G_IDLE;
    endcase
  end

  // Commit FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gstate_r <= G_IDLE;
    else       gstate_r <= gstate_next_s;
  end

  // Shadow, target and active phase registers plus the IMMEDIATE mode bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      immediate_r <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_r[n] <= {PHASE_W{1'b0}};
        target_r[n] <= {PHASE_W{1'b0}};
        active_r[n] <= {PHASE_W{1'b0}};
      end
    end else begin
      if (wr_s && address == 4'd8) immediate_r <= writedata[1];
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_s && address == 4'(n)) shadow_r[n] <= writedata[PHASE_W-1:0];
        if (xfer_imm_s) begin
          target_r[n] <= shadow_r[n];
          active_r[n] <= shadow_r[n];
        end else if (xfer_strobe_s) begin
          target_r[n] <= shadow_r[n];
        end else if (sync_strobe && slew_s[n]) begin
          active_r[n] <= step_next_s[n];
        end
      end
    end
  end

  // Read mux as an AND-OR tree so overlapping fields cannot mask each other.
  always_comb begin
    rdata_s = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      rdata_s[PHASE_W-1:0] = rdata_s[PHASE_W-1:0] |
                             ({PHASE_W{address == 4'(n)}} & shadow_r[n]) |
                             ({PHASE_W{{1'b0, address} == 5'(10 + n)}} & active_r[n]);
      rdata_s[8+n] = rdata_s[8+n] | ((address == 4'd9) & slew_s[n]);
    end
    rdata_s[0] = rdata_s[0] | ((address == 4'd9) & (gstate_r == G_PENDING));
    rdata_s[1] = rdata_s[1] | ((address == 4'd8) & immediate_r);
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     readdata_r <= 32'd0;
    else if (rd_s) readdata_r <= rdata_s;
    else           readdata_r <= readdata_r;
  end

  assign readdata = readdata_r;
  assign busy     = (gstate_r == G_PENDING) | (|slew_s);

  // Active phase words packed onto the output bus.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) out_phase[n*PHASE_W +: PHASE_W] = active_r[n];
  end

endmodule

// File: tb/tb_lvdt_demod_phase_ctrl.sv
// Directed and randomized bench for lvdt_demod_phase_ctrl with a phase-arithmetic reference model.
module tb_lvdt_demod_phase_ctrl;

  localparam int NC = 2;
  localparam int PW = 8;
  localparam int SM = 4;
  localparam int MOD = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        sync_strobe = 1'b0;
  logic [15:0] out_phase;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  int   m_shadow [NC];
  int   m_target [NC];
  int   m_active [NC];
  bit   m_pending;
  bit   m_imm;
  logic [31:0] m_rd;

  lvdt_demod_phase_ctrl #(.NUM_CH(NC), .PHASE_W(PW), .STEP_MAX(SM)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .sync_strobe(sync_strobe), .out_phase(out_phase), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int step(input int a, input int t);
    int d, m;
    d = (t - a + MOD) % MOD;
    if (d < MOD / 2) begin
      m = (d < SM) ? d : SM;
      return (a + m) % MOD;
    end
    m = ((MOD - d) < SM) ? (MOD - d) : SM;
    return (a - m + MOD) % MOD;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = 32'd0;
    if (a < NC) v = m_shadow[a];
    else if (a == 8) v = {30'd0, m_imm, 1'b0};
    else if (a == 9) begin
      v[0] = m_pending;
      for (int n = 0; n < NC; n++) v[8+n] = (m_active[n] != m_target[n]);
    end else if (a >= 10 && a < 10 + NC) v = m_active[a-10];
    return v;
  endfunction

  function automatic logic [15:0] exp_phase();
    return {m_active[1][7:0], m_active[0][7:0]};
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = m_pending;
    for (int n = 0; n < NC; n++) b = b | (m_active[n] != m_target[n]);
    return b;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_phase"}, {16'd0, out_phase}, {16'd0, exp_phase()});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy()});
    chk({tag, "_rdata"}, readdata, m_rd);
  endtask

  // One bus/strobe cycle; the model advances with the inputs seen at the edge.
  task automatic cycle(input int a, input bit wr, input bit rd, input logic [31:0] wd, input bit stb);
    bit commit, xi, xs;
    logic [31:0] rv;
    address = 4'(a); chipselect = wr | rd; write_n = ~wr; read_n = ~rd;
    writedata = wd; sync_strobe = stb;
    @(posedge clk);
    commit = wr && (a == 8) && wd[0];
    rv = model_read(a);
    xi = m_pending && !commit && m_imm;
    xs = m_pending && !commit && !m_imm && stb;
    for (int n = 0; n < NC; n++) begin
      if (xi) begin m_target[n] = m_shadow[n]; m_active[n] = m_shadow[n]; end
      else if (xs) m_target[n] = m_shadow[n];
      else if (stb && m_active[n] != m_target[n]) m_active[n] = step(m_active[n], m_target[n]);
    end
    if (wr && a < NC) m_shadow[a] = int'(wd[7:0]);
    if (wr && a == 8) m_imm = wd[1];
    if (commit) m_pending = 1'b1;
    else if (xi || xs) m_pending = 1'b0;
    if (rd) m_rd = rv;
    #1;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; sync_strobe = 1'b0;
    check_model("cyc");
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    address = 4'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'd77;
    @(posedge clk); @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    for (int n = 0; n < NC; n++) begin m_shadow[n] = 0; m_target[n] = 0; m_active[n] = 0; end
    m_pending = 1'b0; m_imm = 1'b0; m_rd = 32'd0;
    chk({tag, "_rst_phase"}, {16'd0, out_phase}, 32'd0);
    chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rst_rdata"}, readdata, 32'd0);
    reset = 1'b0;
    #2;
  endtask

  initial begin
    do_reset("init");
    cycle(0, 0, 1, 0, 0);
    chk("shadow0_after_rst_write", readdata, 32'd0);

    // Basic commit and slew 0 -> 10.
    cycle(0, 1, 0, 10, 0);
    cycle(8, 1, 0, 1, 0);
    chk("r27_pending_busy", {31'd0, busy}, 32'd1);
    cycle(15, 0, 0, 0, 1);
    chk("r27_s1", {24'd0, out_phase[7:0]}, 32'd0);
    cycle(15, 0, 0, 0, 1);
    chk("r27_s2", {24'd0, out_phase[7:0]}, 32'd4);
    cycle(15, 0, 0, 0, 1);
    chk("r27_s3", {24'd0, out_phase[7:0]}, 32'd8);
    chk("r27_busy_mid", {31'd0, busy}, 32'd1);
    cycle(15, 0, 0, 0, 1);
    chk("r27_s4", {24'd0, out_phase[7:0]}, 32'd10);
    chk("r27_busy_done", {31'd0, busy}, 32'd0);

    // Wrap through zero, then tie at half a turn.
    cycle(0, 1, 0, 250, 0);
    cycle(8, 1, 0, 3, 0);
    cycle(15, 0, 0, 0, 0);
    chk("r28_imm250", {24'd0, out_phase[7:0]}, 32'd250);
    cycle(8, 1, 0, 0, 0);
    cycle(0, 1, 0, 3, 0);
    cycle(8, 1, 0, 1, 0);
    cycle(15, 0, 0, 0, 1);
    cycle(15, 0, 0, 0, 1);
    chk("r28_wrap1", {24'd0, out_phase[7:0]}, 32'd254);
    cycle(15, 0, 0, 0, 1);
    chk("r28_wrap2", {24'd0, out_phase[7:0]}, 32'd2);
    cycle(15, 0, 0, 0, 1);
    chk("r28_wrap3", {24'd0, out_phase[7:0]}, 32'd3);
    cycle(0, 1, 0, 0, 0);
    cycle(8, 1, 0, 3, 0);
    cycle(15, 0, 0, 0, 0);
    cycle(8, 1, 0, 0, 0);
    cycle(0, 1, 0, 128, 0);
    cycle(8, 1, 0, 1, 0);
    cycle(15, 0, 0, 0, 1);
    cycle(15, 0, 0, 0, 1);
    chk("r28_tie1", {24'd0, out_phase[7:0]}, 32'd252);
    cycle(15, 0, 0, 0, 1);
    chk("r28_tie2", {24'd0, out_phase[7:0]}, 32'd248);

    // Immediate commit without a strobe.
    cycle(1, 1, 0, 32'h55, 0);
    cycle(8, 1, 0, 3, 0);
    chk("r29_pending", {31'd0, busy}, 32'd1);
    cycle(15, 0, 0, 0, 0);
    chk("r29_ch1", {24'd0, out_phase[15:8]}, 32'h55);
    chk("r29_busy0", {31'd0, busy}, 32'd0);
    cycle(15, 0, 0, 0, 0);
    chk("r29_busy1", {31'd0, busy}, 32'd0);
    cycle(8, 1, 0, 0, 0);

    // Commit coinciding with a strobe, then a shadow write coinciding with the transfer.
    cycle(0, 1, 0, 20, 0);
    cycle(8, 1, 0, 1, 1);
    cycle(9, 0, 1, 0, 0);
    chk("r30_status_no_xfer", readdata, 32'h1);
    cycle(0, 1, 0, 200, 1);
    cycle(15, 0, 0, 0, 1);
    chk("r30_old_target", {24'd0, out_phase[7:0]}, 32'd124);

    // Reset while slewing and pending.
    cycle(0, 1, 0, 0, 0);
    cycle(8, 1, 0, 3, 0);
    cycle(15, 0, 0, 0, 0);
    cycle(8, 1, 0, 0, 0);
    cycle(0, 1, 0, 40, 0);
    cycle(8, 1, 0, 1, 0);
    cycle(15, 0, 0, 0, 1);
    cycle(15, 0, 0, 0, 1);
    cycle(15, 0, 0, 0, 1);
    chk("r31_mid", {24'd0, out_phase[7:0]}, 32'd8);
    cycle(8, 1, 0, 1, 0);
    do_reset("r31");
    for (int i = 0; i < 3; i++) cycle(15, 0, 0, 0, 1);
    chk("r31_no_move", {16'd0, out_phase}, 32'd0);
    cycle(9, 0, 1, 0, 0);
    chk("r31_status", readdata, 32'd0);

    // Read ACTIVE1 and an unmapped address.
    cycle(1, 1, 0, 32'h77, 0);
    cycle(8, 1, 0, 3, 0);
    cycle(15, 0, 0, 0, 0);
    cycle(11, 0, 1, 0, 0);
    chk("r32_active1", readdata, 32'h77);
    cycle(15, 0, 1, 0, 0);
    chk("r32_unmapped", readdata, 32'd0);
    cycle(8, 0, 1, 0, 0);
    chk("ctrl_read_imm", readdata, 32'h2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int a, op;
      logic [31:0] wd;
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 6))
        0: a = 0;
        1: a = 1;
        2, 3: a = 8;
        4: a = 9;
        5: a = 10 + $urandom_range(0, 1);
        default: a = $urandom_range(0, 15);
      endcase
      wd = $urandom;
      if (a == 8 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      cycle(a, op < 4, op >= 4 && op < 7, wd, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
